// File: rtl/comp_minmax_track.sv
// comp_minmax_track
// Streaming min/max tracker placed after the 16-bit magnitude comparison
// stage. It accepts a framed stream of samples over a valid/ready handshake.
// For each frame it keeps the running minimum, the running maximum and a
// saturating sample count. At frame end it holds one result beat until the
// consumer accepts it.
//
// Build option:
//   COMP_MINMAX_SIGNED_EN - when defined, samples are compared as two's
//                           complement values. When undefined (the default),
//                           samples use unsigned magnitude ordering.
//
// Ports:
//   clk_pad        clock, rising edge
//   rst_n_pad      asynchronous active-low reset
//   in_valid_pad   a sample is offered
//   in_ready_pad   the block can accept a sample (low only while a result is held)
//   in_data_pad    sample value
//   in_last_pad    the offered sample closes its frame
//   out_valid_pad  a frame result is held
//   out_ready_pad  the consumer accepts the result
//   out_min_pad    frame minimum
//   out_max_pad    frame maximum
//   out_cnt_pad    samples in the frame, saturating at all-ones
//   out_flat_pad   every sample of the frame was equal
module comp_minmax_track #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             in_valid_pad,
  output logic             in_ready_pad,
  input  logic [WIDTH-1:0] in_data_pad,
  input  logic             in_last_pad,
  output logic             out_valid_pad,
  input  logic             out_ready_pad,
  output logic [WIDTH-1:0] out_min_pad,
  output logic [WIDTH-1:0] out_max_pad,
  output logic [CNT_W-1:0] out_cnt_pad,
  output logic             out_flat_pad
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACC   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] min_q, max_q, min_d, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flat_q;
  logic             accept;
  logic             below_min, above_max;

  // Ready is decoded from registered state only, so it has no path from in_valid.
  assign in_ready_pad  = (state_q != HOLD);
  assign out_valid_pad = (state_q == HOLD);
  assign accept        = in_valid_pad && in_ready_pad;

  assign out_min_pad  = min_q;
  assign out_max_pad  = max_q;
  assign out_cnt_pad  = cnt_q;
  assign out_flat_pad = flat_q;

  // This uses the same ordering decision as the upstream comparator.
  // Equality counts as neither below nor above, so ties leave min and max alone.
`ifdef COMP_MINMAX_SIGNED_EN
  assign below_min = $signed(in_data_pad) < $signed(min_q);
  assign above_max = $signed(in_data_pad) > $signed(max_q);
`else
  assign below_min = in_data_pad < min_q;
  assign above_max = in_data_pad > max_q;
`endif

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          min_d   = in_data_pad;
          max_d   = in_data_pad;
          cnt_d   = CNT_W'(1);
          state_d = in_last_pad ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (below_min) min_d = in_data_pad;
          if (above_max) max_d = in_data_pad;
          // The count sticks at all-ones instead of wrapping on long frames.
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (in_last_pad) state_d = HOLD;
        end
      end
      HOLD: begin
        // A sample offered in this cycle is not taken; upstream keeps it.
        if (out_ready_pad) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Results are only written on an accept. After the handshake, the last
  // result stays visible until the next frame's first sample overwrites it.
  // The flat flag is computed from the post-update min and max.
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      state_q <= EMPTY;
      min_q   <= '1;
      max_q   <= '0;
      cnt_q   <= '0;
      flat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        min_q  <= min_d;
        max_q  <= max_d;
        cnt_q  <= cnt_d;
        flat_q <= (min_d == max_d);
      end
    end
  end

endmodule

// File: tb/tb_comp_minmax_track.sv
// tb_comp_minmax_track
// Self-checking bench for comp_minmax_track. It uses directed frames followed
// by random frames. The reference model collects each frame's samples in a
// queue. When the last sample arrives, it derives min, max, count and flat
// from the whole frame.
module tb_comp_minmax_track;

  localparam int WIDTH   = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_pad = 1'b0;
  logic             rst_n_pad;
  logic             in_valid_pad;
  logic             in_ready_pad;
  logic [WIDTH-1:0] in_data_pad;
  logic             in_last_pad;
  logic             out_valid_pad;
  logic             out_ready_pad;
  logic [WIDTH-1:0] out_min_pad;
  logic [WIDTH-1:0] out_max_pad;
  logic [CNT_W-1:0] out_cnt_pad;
  logic             out_flat_pad;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] frame_q[$];
  logic             exp_hold = 1'b0;
  logic [WIDTH-1:0] exp_min;
  logic [WIDTH-1:0] exp_max;
  int               exp_cnt;
  logic             exp_flat;
  logic             stim_accepted;

  always #5 clk_pad = ~clk_pad;

  comp_minmax_track #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_pad       (clk_pad),
    .rst_n_pad     (rst_n_pad),
    .in_valid_pad  (in_valid_pad),
    .in_ready_pad  (in_ready_pad),
    .in_data_pad   (in_data_pad),
    .in_last_pad   (in_last_pad),
    .out_valid_pad (out_valid_pad),
    .out_ready_pad (out_ready_pad),
    .out_min_pad   (out_min_pad),
    .out_max_pad   (out_max_pad),
    .out_cnt_pad   (out_cnt_pad),
    .out_flat_pad  (out_flat_pad)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic precedes(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMP_MINMAX_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  task automatic finalizeFrame();
    exp_min = frame_q[0];
    exp_max = frame_q[0];
    foreach (frame_q[i]) begin
      if (precedes(frame_q[i], exp_min)) exp_min = frame_q[i];
      if (precedes(exp_max, frame_q[i])) exp_max = frame_q[i];
    end
    exp_cnt  = (frame_q.size() > CNT_MAX) ? CNT_MAX : frame_q.size();
    exp_flat = (exp_min == exp_max);
    frame_q.delete();
    exp_hold = 1'b1;
  endtask

  // applyStimulus is entered just after a rising edge and returns just after
  // the next rising edge. It checks the DUT on the falling edge in between.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic l,
                               input logic ordy);
    logic accept, hs;
    in_valid_pad  = v;
    in_data_pad   = d;
    in_last_pad   = l;
    out_ready_pad = ordy;
    @(negedge clk_pad);
    checkOutput("in_ready", 32'(in_ready_pad), 32'(!exp_hold));
    checkOutput("out_valid", 32'(out_valid_pad), 32'(exp_hold));
    if (exp_hold) begin
      checkOutput("out_min", 32'(out_min_pad), 32'(exp_min));
      checkOutput("out_max", 32'(out_max_pad), 32'(exp_max));
      checkOutput("out_cnt", 32'(out_cnt_pad), 32'(exp_cnt));
      checkOutput("out_flat", 32'(out_flat_pad), 32'(exp_flat));
    end
    accept = v && !exp_hold;
    hs     = exp_hold && ordy;
    @(posedge clk_pad);
    #1;
    stim_accepted = accept;
    if (hs) begin
      exp_hold = 1'b0;
    end else if (accept) begin
      frame_q.push_back(d);
      if (l) finalizeFrame();
    end
  endtask

  // Offers one sample until it is taken. In random mode, out_ready toggles
  // randomly, and it is forced high after a few tries so the wait stays bounded.
  task automatic sendSample(input logic [WIDTH-1:0] d, input logic l, input bit rnd_ready);
    int tries = 0;
    stim_accepted = 1'b0;
    while (!stim_accepted && tries < 40) begin
      applyStimulus(1'b1, d, l, (!rnd_ready || tries > 8) ? 1'b1 : 1'($urandom_range(0, 1)));
      tries++;
    end
    if (!stim_accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drainResult();
    int tries = 0;
    while (exp_hold && tries < 20) begin
      applyStimulus(1'b0, WIDTH'($urandom), 1'($urandom), 1'b1);
      tries++;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready_pad), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid_pad), 32'd0);
    checkOutput({tag, "_min"}, 32'(out_min_pad), 32'hFFFF);
    checkOutput({tag, "_max"}, 32'(out_max_pad), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(out_cnt_pad), 32'd0);
    checkOutput({tag, "_flat"}, 32'(out_flat_pad), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] first_frame[5];
    logic [WIDTH-1:0] base, d;
    int len;

    first_frame = '{16'd5, 16'd3, 16'd9, 16'd9, 16'd4};
    rst_n_pad     = 1'b0;
    in_valid_pad  = 1'b0;
    in_data_pad   = '0;
    in_last_pad   = 1'b0;
    out_ready_pad = 1'b0;
    repeat (3) @(posedge clk_pad);
    #1;
    checkResetValues("reset");
    @(negedge clk_pad);
    rst_n_pad = 1'b1;
    @(posedge clk_pad);
    #1;

    // Frame 5,3,9,9,4 with out_ready held high.
    foreach (first_frame[i]) sendSample(first_frame[i], (i == 4), 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Single-sample frame.
    sendSample(16'h1234, 1'b1, 1'b0);
    drainResult();

    // Ordering across the sign boundary.
    sendSample(16'h7FFF, 1'b0, 1'b0);
    sendSample(16'h8000, 1'b1, 1'b0);
    drainResult();

    // Backpressure: a new sample is offered during ten stalled HOLD cycles.
    sendSample(16'h0010, 1'b0, 1'b0);
    sendSample(16'h0020, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b1);
    checkOutput("bp_next_accept", 32'(stim_accepted), 32'd1);
    drainResult();

    // Count saturation.
    for (int i = 0; i < 300; i++) sendSample(16'h0042, (i == 299), 1'b0);
    drainResult();

    // Reset in the middle of a four-sample frame.
    sendSample(16'h0010, 1'b0, 1'b0);
    sendSample(16'h0020, 1'b0, 1'b0);
    in_valid_pad = 1'b0;
    rst_n_pad    = 1'b0;
    #1;
    checkResetValues("midreset");
    frame_q.delete();
    exp_hold = 1'b0;
    repeat (2) @(posedge clk_pad);
    @(negedge clk_pad);
    rst_n_pad = 1'b1;
    @(posedge clk_pad);
    #1;
    sendSample(16'd1, 1'b0, 1'b0);
    sendSample(16'd2, 1'b1, 1'b0);
    drainResult();

    // Random frames with idle gaps, ignored data and random out_ready.
    for (int f = 0; f < 40; f++) begin
      len  = $urandom_range(1, 6);
      base = WIDTH'($urandom);
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2))
          applyStimulus(1'b0, WIDTH'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        d = ($urandom_range(0, 2) == 0) ? base : WIDTH'($urandom);
        sendSample(d, (j == len - 1), 1'b1);
      end
    end
    drainResult();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
